frame_config_loader: RTL and testbench
======================================

// Module: frame_config_loader
// PURPOSE
//  Drives the FrameData/FrameStrobe pair that programs a column of tile config frame latches.
//  Consumes a 32-bit bitstream word stream (valid/ready), hunts for a sync word and parses frame packets.
//  Writes each frame for this column's COL_ID onto FrameData, then pulses exactly one FrameStrobe bit
//  with setup and hold cycles. Sits between the bitstream source (UART/JTAG/host) and the column config memories.
// PARAMETERS
//  MAX_FRAMES_PER_COL  20      number of FrameStrobe lines (frames per column)
//  FRAME_BITS_PER_ROW  32      bits per row; equals the s_data word width
//  NUM_ROWS            1       data words per frame; FrameData = NUM_ROWS*FRAME_BITS_PER_ROW bits
//  COL_ID              8'd0    column address this loader answers to
// PORTS
//  CLK          in   1                     clock
//  resetn       in   1                     asynchronous active-low reset
//  s_data       in   FRAME_BITS_PER_ROW    bitstream word
//  s_valid      in   1                     s_data valid
//  s_ready      out  1                     word accepted when s_valid & s_ready
//  FrameData    out  NUM_ROWS*FRAME_BITS_PER_ROW  frame bits; row r = bits [r*FBPR +: FBPR]
//  FrameStrobe  out  MAX_FRAMES_PER_COL    one-hot latch enable, one cycle wide
//  sync_ok      out  1                     stream synchronised
//  busy         out  1                     high in any state other than HUNT and HDR
//  err          out  1                     sticky error; cleared by reset or by the next SYNC word
//  frame_count  out  16                    committed strobes (FRAME_COUNT_EN only)
// BEHAVIOUR
//  Reset values: s_ready=0, FrameData=0, FrameStrobe=0, sync_ok=0, busy=0, err=0, frame_count=0.
//  Reset is asynchronous; asserting it mid-strobe clears FrameStrobe immediately.
//  SYNC=32'hFAB0_FAB1, DESYNC=32'hFAB0_0000.
//  Header word: [31:24]=8'hA5, [23:16]=column, [15:8] reserved (ignored), [7:0]=frame index.
//  States: HUNT, HDR, DATA, SETUP, STROBE, HOLD. s_ready=1 only in HUNT, HDR and DATA.
//  HUNT: every word is consumed.
//   - SYNC: go to HDR, set sync_ok, clear err.
//   - Any other word: discarded, no flag.
//  HDR:
//   - SYNC: ignored, stay in HDR.
//   - DESYNC: go to HUNT, clear sync_ok.
//   - Marker != A5: set err, clear sync_ok, go to HUNT.
//   - Otherwise: latch column and index, clear row counter, go to DATA.
//  DATA: word k (0..NUM_ROWS-1) is written into FrameData row k on the cycle after its handshake,
//   but only when column==COL_ID and index<MAX_FRAMES_PER_COL.
//   - Otherwise all NUM_ROWS words are still consumed and FrameData is untouched.
//   - After the last word: go to SETUP if a write is due, else back to HDR.
//   - Index >= MAX_FRAMES_PER_COL on a matching column: set err, no strobe.
//   - A mismatched column is silently skipped (frame belongs to another column).
//   - SYNC/DESYNC values in DATA are treated as data.
//  Timing, with the last data handshake in cycle t:
//   - FrameData holds the final value from t+1 (SETUP).
//   - FrameStrobe[index]=1 during t+2 only (STROBE); all other bits stay 0.
//   - FrameData is held through t+3 (HOLD); s_ready returns to 1 at t+4 (HDR).
//  FrameData keeps its value between frames; it changes only in DATA of a matching frame.
//  s_valid low in DATA stalls with no timeout; the row counter is preserved.
//  FrameStrobe is registered and never glitches; at most one bit is set in any cycle.
// CONFIGURATION
//  FRAME_COUNT_EN defined: frame_count port exists.
//   - Increments by 1 in each STROBE cycle, saturates at 16'hFFFF, reset to 0.
//   - Not cleared by SYNC.
//  FRAME_COUNT_EN undefined: port and counter are absent; all other behaviour is identical.
// TESTING
//  1 Basic write, NUM_ROWS=1: SYNC, then A500_0003, then DEADBEEF.
//    -> FrameData=DEADBEEF from t+1; FrameStrobe=20'h00008 for one cycle at t+2; s_ready low t+1..t+3.
//  2 Column mismatch: SYNC, A501_0002, 12345678 -> no strobe, FrameData unchanged, err=0, back in HDR.
//  3 Bad index: SYNC, A500_0014 (index 20), data -> no strobe, err=1; a later SYNC clears err.
//  4 Bad marker and desync:
//    - SYNC, 5500_0001 -> err=1, sync_ok=0; the following header is discarded until the next SYNC.
//    - SYNC, FAB0_0000 -> sync_ok=0, no err.
//  5 NUM_ROWS=2 with an s_valid gap: header A500_0000, then 11111111, idle 5 cycles, 22222222.
//    -> FrameData=22222222_11111111; single strobe on bit 0.
//  6 Reset asserted during STROBE -> FrameStrobe=0 with no clock edge; after release, back in HUNT with sync_ok=0.
//    With FRAME_COUNT_EN: 3 good frames -> frame_count=3.

Source files
------------

// File: rtl/frame_config_loader.sv
// Column config frame loader: hunts for SYNC, parses frame packets and drives FrameData/FrameStrobe.
// Optional frame_count port and counter when FRAME_COUNT_EN is defined.
module frame_config_loader #(
    parameter int unsigned MAX_FRAMES_PER_COL = 20,
    parameter int unsigned FRAME_BITS_PER_ROW = 32,
    parameter int unsigned NUM_ROWS           = 1,
    parameter logic [7:0]  COL_ID             = 8'd0
) (
    input  logic                                   CLK,
    input  logic                                   resetn,
    input  logic [FRAME_BITS_PER_ROW-1:0]          s_data,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    output logic [NUM_ROWS*FRAME_BITS_PER_ROW-1:0] FrameData,
    output logic [MAX_FRAMES_PER_COL-1:0]          FrameStrobe,
    output logic                                   sync_ok,
    output logic                                   busy,
    output logic                                   err
`ifdef FRAME_COUNT_EN
    ,
    output logic [15:0]                            frame_count
`endif
);

    localparam logic [FRAME_BITS_PER_ROW-1:0] SyncWord   = 32'hFAB0_FAB1;
    localparam logic [FRAME_BITS_PER_ROW-1:0] DesyncWord = 32'hFAB0_0000;
    localparam int unsigned RowW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    typedef enum logic [2:0] {
        StHunt,
        StHdr,
        StData,
        StSetup,
        StStrobe,
        StHold
    } stateT;

    stateT stateQ, stateD;

    logic [NUM_ROWS*FRAME_BITS_PER_ROW-1:0] frameDataQ, frameDataD;
    logic [MAX_FRAMES_PER_COL-1:0]          strobeQ, strobeD;
    logic [7:0]                             colQ, colD;
    logic [7:0]                             idxQ, idxD;
    logic [RowW-1:0]                        rowQ, rowD;
    logic                                   readyQ, readyD;
    logic                                   syncOkQ, syncOkD;
    logic                                   errQ, errD;

    logic handshake;
    logic isSync;
    logic isDesync;
    logic markerOk;
    logic colMatch;
    logic idxOk;
    logic writeDue;
    logic lastRow;

    assign handshake = s_valid & readyQ;
    assign isSync    = (s_data == SyncWord);
    assign isDesync  = (s_data == DesyncWord);
    assign markerOk  = (s_data[31:24] == 8'hA5);
    assign colMatch  = (colQ == COL_ID);
    assign idxOk     = (32'(idxQ) < MAX_FRAMES_PER_COL);
    assign writeDue  = colMatch & idxOk;
    assign lastRow   = (32'(rowQ) == NUM_ROWS - 1);

    // State register
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            stateQ <= StHunt;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state logic
    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StHunt: begin
                if (handshake && isSync) stateD = StHdr;
            end
            StHdr: begin
                if (handshake && !isSync) begin
                    if (isDesync || !markerOk) stateD = StHunt;
                    else                       stateD = StData;
                end
            end
            StData: begin
                if (handshake && lastRow) stateD = writeDue ? StSetup : StHdr;
            end
            StSetup:  stateD = StStrobe;
            StStrobe: stateD = StHold;
            StHold:   stateD = StHdr;
            default:  stateD = StHunt;
        endcase
    end

    // Output and datapath next values; all outputs are registered so nothing glitches
    always_comb begin
        frameDataD = frameDataQ;
        colD       = colQ;
        idxD       = idxQ;
        rowD       = rowQ;
        syncOkD    = syncOkQ;
        errD       = errQ;
        readyD     = (stateD == StHunt) || (stateD == StHdr) || (stateD == StData);
        strobeD    = '0;
        if (stateD == StStrobe) begin
            for (int unsigned i = 0; i < MAX_FRAMES_PER_COL; i++) begin
                strobeD[i] = (32'(idxQ) == i);
            end
        end

        unique case (stateQ)
            StHunt: begin
                if (handshake && isSync) begin
                    syncOkD = 1'b1;
                    errD    = 1'b0;
                end
            end
            StHdr: begin
                if (handshake) begin
                    // A repeated SYNC keeps the state but still clears a sticky error
                    if (isSync) begin
                        errD = 1'b0;
                    end else if (isDesync) begin
                        syncOkD = 1'b0;
                    end else if (!markerOk) begin
                        errD    = 1'b1;
                        syncOkD = 1'b0;
                    end else begin
                        colD = s_data[23:16];
                        idxD = s_data[7:0];
                        rowD = '0;
                    end
                end
            end
            StData: begin
                if (handshake) begin
                    if (writeDue) begin
                        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
                            if (32'(rowQ) == r) begin
                                frameDataD[r*FRAME_BITS_PER_ROW +: FRAME_BITS_PER_ROW] = s_data;
                            end
                        end
                    end
                    if (lastRow) begin
                        rowD = '0;
                        if (colMatch && !idxOk) errD = 1'b1;
                    end else begin
                        rowD = rowQ + RowW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            frameDataQ <= '0;
            strobeQ    <= '0;
            colQ       <= '0;
            idxQ       <= '0;
            rowQ       <= '0;
            readyQ     <= 1'b0;
            syncOkQ    <= 1'b0;
            errQ       <= 1'b0;
        end else begin
            frameDataQ <= frameDataD;
            strobeQ    <= strobeD;
            colQ       <= colD;
            idxQ       <= idxD;
            rowQ       <= rowD;
            readyQ     <= readyD;
            syncOkQ    <= syncOkD;
            errQ       <= errD;
        end
    end

    assign s_ready     = readyQ;
    assign FrameData   = frameDataQ;
    assign FrameStrobe = strobeQ;
    assign sync_ok     = syncOkQ;
    assign err         = errQ;
    assign busy        = (stateQ != StHunt) && (stateQ != StHdr);

`ifdef FRAME_COUNT_EN
    logic [15:0] frameCountQ;

    // Saturating count of committed strobes; SYNC does not touch it
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            frameCountQ <= '0;
        end else if (stateQ == StStrobe && frameCountQ != 16'hFFFF) begin
            frameCountQ <= frameCountQ + 16'd1;
        end
    end

    assign frame_count = frameCountQ;
`endif

endmodule

// File: tb/tb_frame_config_loader.sv
// Directed bench for frame_config_loader: one instance with NUM_ROWS=1, one with NUM_ROWS=2.
module tb_frame_config_loader;

    localparam logic [31:0] Sync   = 32'hFAB0_FAB1;
    localparam logic [31:0] Desync = 32'hFAB0_0000;

    logic        CLK = 1'b0;
    logic        resetn;
    logic [31:0] s1Data, s2Data;
    logic        s1Valid, s2Valid;
    logic        s1Ready, s2Ready;
    logic [31:0] s1Frame;
    logic [63:0] s2Frame;
    logic [19:0] s1Strobe, s2Strobe;
    logic        s1SyncOk, s2SyncOk, s1Busy, s2Busy, s1Err, s2Err;
`ifdef FRAME_COUNT_EN
    logic [15:0] s1Count, s2Count;
`endif

    int nChecks = 0;
    int nFails  = 0;

    always #5 CLK = ~CLK;

    frame_config_loader #(
        .MAX_FRAMES_PER_COL(20), .FRAME_BITS_PER_ROW(32), .NUM_ROWS(1), .COL_ID(8'd0)
    ) dut1 (
        .CLK(CLK), .resetn(resetn), .s_data(s1Data), .s_valid(s1Valid), .s_ready(s1Ready),
        .FrameData(s1Frame), .FrameStrobe(s1Strobe), .sync_ok(s1SyncOk), .busy(s1Busy),
        .err(s1Err)
`ifdef FRAME_COUNT_EN
        , .frame_count(s1Count)
`endif
    );

    frame_config_loader #(
        .MAX_FRAMES_PER_COL(20), .FRAME_BITS_PER_ROW(32), .NUM_ROWS(2), .COL_ID(8'd0)
    ) dut2 (
        .CLK(CLK), .resetn(resetn), .s_data(s2Data), .s_valid(s2Valid), .s_ready(s2Ready),
        .FrameData(s2Frame), .FrameStrobe(s2Strobe), .sync_ok(s2SyncOk), .busy(s2Busy),
        .err(s2Err)
`ifdef FRAME_COUNT_EN
        , .frame_count(s2Count)
`endif
    );

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Present one word and return 1ns after the edge on which it was accepted.
    task automatic sendWord(input bit sel, input logic [31:0] w);
        int n;
        n = 0;
        if (sel) begin s2Data = w; s2Valid = 1'b1; end
        else     begin s1Data = w; s1Valid = 1'b1; end
        while (!(sel ? s2Ready : s1Ready) && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        if (n >= 50) checkVal("s_ready timeout", 64'(sel ? s2Ready : s1Ready), 64'd1);
        else begin
            @(posedge CLK); #1;
        end
        s1Valid = 1'b0;
        s2Valid = 1'b0;
    endtask

    // OR of FrameStrobe over the current and the following cycles-1 cycles.
    task automatic watchStrobe(input bit sel, input int cycles, output logic [19:0] seen);
        seen = sel ? s2Strobe : s1Strobe;
        for (int i = 1; i < cycles; i++) begin
            @(posedge CLK); #1;
            seen |= sel ? s2Strobe : s1Strobe;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] seen;
        resetn = 1'b0;
        s1Data = '0; s2Data = '0; s1Valid = 1'b0; s2Valid = 1'b0;
        #2;
        checkVal("reset s_ready", 64'(s1Ready), 64'd0);
        checkVal("reset FrameData", 64'(s1Frame), 64'd0);
        checkVal("reset FrameStrobe", 64'(s1Strobe), 64'd0);
        checkVal("reset sync_ok", 64'(s1SyncOk), 64'd0);
        checkVal("reset busy", 64'(s1Busy), 64'd0);
        checkVal("reset err", 64'(s1Err), 64'd0);
        @(posedge CLK); @(posedge CLK); #1;
        resetn = 1'b1;

        // 1: basic write of frame 3
        sendWord(0, Sync);
        checkVal("t1 sync_ok", 64'(s1SyncOk), 64'd1);
        sendWord(0, 32'hA500_0003);
        sendWord(0, 32'hDEAD_BEEF);
        checkVal("t1 data t+1", 64'(s1Frame), 64'hDEAD_BEEF);
        checkVal("t1 strobe t+1", 64'(s1Strobe), 64'd0);
        checkVal("t1 ready t+1", 64'(s1Ready), 64'd0);
        checkVal("t1 busy t+1", 64'(s1Busy), 64'd1);
        @(posedge CLK); #1;
        checkVal("t1 strobe t+2", 64'(s1Strobe), 64'h0_0008);
        checkVal("t1 ready t+2", 64'(s1Ready), 64'd0);
        @(posedge CLK); #1;
        checkVal("t1 strobe t+3", 64'(s1Strobe), 64'd0);
        checkVal("t1 data t+3", 64'(s1Frame), 64'hDEAD_BEEF);
        checkVal("t1 ready t+3", 64'(s1Ready), 64'd0);
        @(posedge CLK); #1;
        checkVal("t1 ready t+4", 64'(s1Ready), 64'd1);
        checkVal("t1 busy t+4", 64'(s1Busy), 64'd0);
`ifdef FRAME_COUNT_EN
        checkVal("t1 frame_count", 64'(s1Count), 64'd1);
`endif

        // 2: frame for column 1 is skipped
        sendWord(0, Sync);
        sendWord(0, 32'hA501_0002);
        sendWord(0, 32'h1234_5678);
        checkVal("t2 busy", 64'(s1Busy), 64'd0);
        checkVal("t2 ready", 64'(s1Ready), 64'd1);
        watchStrobe(0, 3, seen);
        checkVal("t2 no strobe", 64'(seen), 64'd0);
        checkVal("t2 data kept", 64'(s1Frame), 64'hDEAD_BEEF);
        checkVal("t2 err", 64'(s1Err), 64'd0);

        // 3: index 20 is out of range
        sendWord(0, Sync);
        sendWord(0, 32'hA500_0014);
        sendWord(0, 32'hAAAA_5555);
        checkVal("t3 err set", 64'(s1Err), 64'd1);
        watchStrobe(0, 3, seen);
        checkVal("t3 no strobe", 64'(seen), 64'd0);
        checkVal("t3 data kept", 64'(s1Frame), 64'hDEAD_BEEF);
        sendWord(0, Sync);
        checkVal("t3 err cleared", 64'(s1Err), 64'd0);
        checkVal("t3 sync_ok", 64'(s1SyncOk), 64'd1);

        // 4: bad marker, then a valid-looking packet discarded while hunting, then desync
        sendWord(0, 32'h5500_0001);
        checkVal("t4 bad marker err", 64'(s1Err), 64'd1);
        checkVal("t4 bad marker sync_ok", 64'(s1SyncOk), 64'd0);
        sendWord(0, 32'hA500_0001);
        sendWord(0, 32'h0102_0304);
        watchStrobe(0, 3, seen);
        checkVal("t4 hunt no strobe", 64'(seen), 64'd0);
        checkVal("t4 hunt data kept", 64'(s1Frame), 64'hDEAD_BEEF);
        checkVal("t4 hunt sync_ok", 64'(s1SyncOk), 64'd0);
        sendWord(0, Sync);
        checkVal("t4 resync err", 64'(s1Err), 64'd0);
        checkVal("t4 resync sync_ok", 64'(s1SyncOk), 64'd1);
        sendWord(0, Desync);
        checkVal("t4 desync sync_ok", 64'(s1SyncOk), 64'd0);
        checkVal("t4 desync err", 64'(s1Err), 64'd0);

        // 5: two-row frame with a 5-cycle valid gap
        sendWord(1, Sync);
        sendWord(1, 32'hA500_0000);
        sendWord(1, 32'h1111_1111);
        watchStrobe(1, 5, seen);
        checkVal("t5 gap no strobe", 64'(seen), 64'd0);
        checkVal("t5 gap busy", 64'(s2Busy), 64'd1);
        sendWord(1, 32'h2222_2222);
        checkVal("t5 data", s2Frame, 64'h2222_2222_1111_1111);
        @(posedge CLK); #1;
        checkVal("t5 strobe", 64'(s2Strobe), 64'h0_0001);
        watchStrobe(1, 3, seen);
        checkVal("t5 single strobe", 64'(seen), 64'h0_0001);

        // 6: asynchronous reset in the middle of a strobe
        sendWord(0, Sync);
        sendWord(0, 32'hA500_0005);
        sendWord(0, 32'h0BAD_F00D);
        @(posedge CLK); #1;
        checkVal("t6 strobe before reset", 64'(s1Strobe), 64'h0_0020);
        #2 resetn = 1'b0;
        #1;
        checkVal("t6 strobe async clear", 64'(s1Strobe), 64'd0);
        checkVal("t6 data async clear", 64'(s1Frame), 64'd0);
        @(posedge CLK); #1;
        resetn = 1'b1;
        sendWord(0, 32'hA500_0001);
        sendWord(0, 32'h0BAD_F00D);
        watchStrobe(0, 3, seen);
        checkVal("t6 hunt no strobe", 64'(seen), 64'd0);
        checkVal("t6 hunt sync_ok", 64'(s1SyncOk), 64'd0);
        checkVal("t6 hunt busy", 64'(s1Busy), 64'd0);
        checkVal("t6 hunt data", 64'(s1Frame), 64'd0);

`ifdef FRAME_COUNT_EN
        checkVal("fc after reset", 64'(s1Count), 64'd0);
        sendWord(0, Sync);
        for (int f = 0; f < 3; f++) begin
            sendWord(0, 32'hA500_0001);
            sendWord(0, 32'h5A5A_0000 | 32'(f));
        end
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        checkVal("fc three frames", 64'(s1Count), 64'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
        $finish;
    end

endmodule
